// File: rtl/cachepool_pkg.sv
// Shared types and constants for the CachePool hardware boot sequencer.
package cachepool_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_REQ,
    ST_RSP,
    ST_WAKE,
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } boot_state_e;

  localparam logic [47:0] PeriStartAddr               = 48'h0000_1000_0000;
  localparam logic [47:0] CLUSTER_BOOT_CONTROL_OFFSET = 48'h0000_0000_0040;
  localparam logic [47:0] DefaultBootRegAddr          = PeriStartAddr + CLUSTER_BOOT_CONTROL_OFFSET;

  localparam int unsigned DefaultSettleCycles   = 1000;
  localparam int unsigned DefaultWatchdogCycles = 2 ** 20;

  // Width of a down-counter that must hold max_val; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/cachepool_boot_cnt.sv
// Loadable down-counter with a zero flag; it holds at zero once reached.
module cachepool_boot_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [Width-1:0] r_count;

  // Load has priority over counting; the count saturates at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - Width'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/cachepool_boot_ctrl.sv
// CachePool boot sequencer: settle, write entry point to the boot-control
// register over a reqrsp port, pulse debug_req, then wait for eoc.
// Optional eoc watchdog with timeout_o: define CACHEPOOL_BOOT_WATCHDOG_EN.
module cachepool_boot_ctrl
  import cachepool_pkg::*;
#(
  parameter int unsigned          AddrWidth       = 48,
  parameter int unsigned          DataWidth       = 32,
  parameter logic [AddrWidth-1:0] BootRegAddr     = AddrWidth'(DefaultBootRegAddr),
  parameter int unsigned          SettleCycles    = DefaultSettleCycles,
  parameter int unsigned          WakePulseCycles = 1,
  parameter int unsigned          WatchdogCycles  = DefaultWatchdogCycles
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [DataWidth-1:0]   entry_point_i,
  output logic [AddrWidth-1:0]   req_addr_o,
  output logic [DataWidth-1:0]   req_data_o,
  output logic                   req_write_o,
  output logic [DataWidth/8-1:0] req_strb_o,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  input  logic                   rsp_valid_i,
  input  logic                   rsp_error_i,
  output logic                   rsp_ready_o,
  output logic                   debug_req_o,
  input  logic                   eoc_i,
  output logic                   busy_o,
  output logic                   done_o,
`ifdef CACHEPOOL_BOOT_WATCHDOG_EN
  output logic                   timeout_o,
`endif
  output logic                   error_o
);

  // Counters are loaded with N-1 so that the zero flag marks the last cycle
  // of each N-cycle window and the state can leave on that same edge.
  localparam int unsigned SettleW = cnt_width(SettleCycles);
  localparam int unsigned WakeW   = cnt_width(WakePulseCycles);
  localparam logic [SettleW-1:0] SettleLoad =
    SettleW'((SettleCycles > 0) ? SettleCycles - 1 : 0);
  localparam logic [WakeW-1:0] WakeLoad =
    WakeW'((WakePulseCycles > 0) ? WakePulseCycles - 1 : 0);

  if (WakePulseCycles == 0 || WatchdogCycles == 0) begin : g_bad_param
    $error("WakePulseCycles and WatchdogCycles must be at least 1");
  end

  boot_state_e          r_state;
  boot_state_e          w_state_next;
  logic [DataWidth-1:0] r_entry;
  logic                 w_start_acc;
  logic                 w_settle_zero;
  logic                 w_wake_zero;
  logic                 w_wake_load;
  logic                 w_run_enter;
  logic                 w_wdog_expired;

  assign w_start_acc = start_i && (r_state inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign w_wake_load = (r_state == ST_RSP) && rsp_valid_i && !rsp_error_i;
  assign w_run_enter = (r_state == ST_WAKE) && w_wake_zero;

  cachepool_boot_cnt #(.Width(SettleW)) u_settle_cnt (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_start_acc),
    .i_load_val (SettleLoad),
    .i_en       (r_state == ST_SETTLE),
    .o_zero     (w_settle_zero)
  );

  cachepool_boot_cnt #(.Width(WakeW)) u_wake_cnt (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_wake_load),
    .i_load_val (WakeLoad),
    .i_en       (r_state == ST_WAKE),
    .o_zero     (w_wake_zero)
  );

`ifdef CACHEPOOL_BOOT_WATCHDOG_EN
  localparam int unsigned WdogW = cnt_width(WatchdogCycles);
  localparam logic [WdogW-1:0] WdogLoad = WdogW'(WatchdogCycles - 1);

  logic r_timeout;

  cachepool_boot_cnt #(.Width(WdogW)) u_wdog_cnt (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_run_enter),
    .i_load_val (WdogLoad),
    .i_en       (r_state == ST_RUN),
    .o_zero     (w_wdog_expired)
  );

  // Timeout flag: set with the watchdog abort, cleared by a new accepted start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timeout <= 1'b0;
    end else if (w_start_acc) begin
      r_timeout <= 1'b0;
    end else if ((r_state == ST_RUN) && !eoc_i && w_wdog_expired) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_wdog_expired = 1'b0;
`endif

  // State register and entry-point latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_entry <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_acc) begin
        r_entry <= entry_point_i;
      end
    end
  end

  // Next-state logic; eoc takes priority over a same-cycle watchdog expiry.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          w_state_next = (SettleCycles == 0) ? ST_REQ : ST_SETTLE;
        end
      end
      ST_SETTLE: if (w_settle_zero) w_state_next = ST_REQ;
      ST_REQ:    if (req_ready_i)   w_state_next = ST_RSP;
      ST_RSP: begin
        if (rsp_valid_i) begin
          w_state_next = rsp_error_i ? ST_ERROR : ST_WAKE;
        end
      end
      ST_WAKE: if (w_wake_zero) w_state_next = ST_RUN;
      ST_RUN: begin
        if (eoc_i) begin
          w_state_next = ST_DONE;
        end else if (w_wdog_expired) begin
          w_state_next = ST_ERROR;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Moore output decode; request fields are zero whenever valid is low.
  always_comb begin
    req_valid_o = 1'b0;
    req_addr_o  = '0;
    req_data_o  = '0;
    req_write_o = 1'b0;
    req_strb_o  = '0;
    rsp_ready_o = 1'b0;
    debug_req_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    error_o     = 1'b0;
    unique case (r_state)
      ST_SETTLE: busy_o = 1'b1;
      ST_REQ: begin
        busy_o      = 1'b1;
        req_valid_o = 1'b1;
        req_addr_o  = BootRegAddr;
        req_data_o  = r_entry;
        req_write_o = 1'b1;
        req_strb_o  = '1;
      end
      ST_RSP: begin
        busy_o      = 1'b1;
        rsp_ready_o = 1'b1;
      end
      ST_WAKE: begin
        busy_o      = 1'b1;
        debug_req_o = 1'b1;
      end
      ST_RUN:   busy_o  = 1'b1;
      ST_DONE:  done_o  = 1'b1;
      ST_ERROR: error_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cachepool_boot_ctrl.sv
// Directed bench for cachepool_boot_ctrl (SettleCycles=4, WakePulseCycles=1,
// WatchdogCycles=50). Watchdog vectors run when CACHEPOOL_BOOT_WATCHDOG_EN is defined.
module tb_cachepool_boot_ctrl;

  localparam int unsigned AW     = 48;
  localparam int unsigned DW     = 32;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned WAKE   = 1;
  localparam int unsigned WDOG   = 50;
  localparam logic [AW-1:0] BOOT_ADDR = 48'h0000_5000_0040;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [DW-1:0]   entry;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_data;
  logic            req_write;
  logic [DW/8-1:0] req_strb;
  logic            req_valid;
  logic            req_ready;
  logic            rsp_valid;
  logic            rsp_error;
  logic            rsp_ready;
  logic            debug_req;
  logic            eoc;
  logic            busy;
  logic            done;
  logic            error;
`ifdef CACHEPOOL_BOOT_WATCHDOG_EN
  logic            timeout;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  cachepool_boot_ctrl #(
    .AddrWidth       (AW),
    .DataWidth       (DW),
    .BootRegAddr     (BOOT_ADDR),
    .SettleCycles    (SETTLE),
    .WakePulseCycles (WAKE),
    .WatchdogCycles  (WDOG)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .entry_point_i (entry),
    .req_addr_o    (req_addr),
    .req_data_o    (req_data),
    .req_write_o   (req_write),
    .req_strb_o    (req_strb),
    .req_valid_o   (req_valid),
    .req_ready_i   (req_ready),
    .rsp_valid_i   (rsp_valid),
    .rsp_error_i   (rsp_error),
    .rsp_ready_o   (rsp_ready),
    .debug_req_o   (debug_req),
    .eoc_i         (eoc),
    .busy_o        (busy),
    .done_o        (done),
`ifdef CACHEPOOL_BOOT_WATCHDOG_EN
    .timeout_o     (timeout),
`endif
    .error_o       (error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".valid"}, 64'(req_valid), 64'd0);
    check({tag, ".addr"},  64'(req_addr),  64'd0);
    check({tag, ".data"},  64'(req_data),  64'd0);
    check({tag, ".write"}, 64'(req_write), 64'd0);
    check({tag, ".strb"},  64'(req_strb),  64'd0);
    check({tag, ".rspr"},  64'(rsp_ready), 64'd0);
    check({tag, ".dbg"},   64'(debug_req), 64'd0);
    check({tag, ".busy"},  64'(busy),      64'd0);
    check({tag, ".done"},  64'(done),      64'd0);
    check({tag, ".err"},   64'(error),     64'd0);
  endtask

  task automatic start_seq(input logic [DW-1:0] ep);
    start = 1'b1;
    entry = ep;
    tick();
    start = 1'b0;
    entry = 32'hFFFF_FFFF;
  endtask

  task automatic run_to_run(input logic [DW-1:0] ep);
    start_seq(ep);
    repeat (SETTLE) tick();
    tick();
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; start = 1'b0; entry = '0; req_ready = 1'b1;
    rsp_valid = 1'b0; rsp_error = 1'b0; eoc = 1'b0;
    tick();
    tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();
    check_quiet("idle");

    // Basic sequence: valid appears SETTLE+1 cycles after start.
    start_seq(32'h8000_3000);
    check("s1.busy", 64'(busy), 64'd1);
    for (int i = 0; i < int'(SETTLE); i++) begin
      check("s1.settle_valid", 64'(req_valid), 64'd0);
      tick();
    end
    check("s1.valid", 64'(req_valid), 64'd1);
    check("s1.addr",  64'(req_addr),  64'(BOOT_ADDR));
    check("s1.data",  64'(req_data),  64'h8000_3000);
    check("s1.strb",  64'(req_strb),  64'hF);
    check("s1.write", 64'(req_write), 64'd1);
    check("s1.rspr_in_req", 64'(rsp_ready), 64'd0);
    tick();
    check("s1.rsp_valid", 64'(req_valid), 64'd0);
    check("s1.rsp_addr",  64'(req_addr),  64'd0);
    check("s1.rsp_ready", 64'(rsp_ready), 64'd1);
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    check("s1.wake_dbg", 64'(debug_req), 64'd1);
    for (int i = 0; i < 19; i++) begin
      tick();
      check("s1.run_dbg",  64'(debug_req), 64'd0);
      check("s1.run_done", 64'(done),      64'd0);
      check("s1.run_busy", 64'(busy),      64'd1);
    end
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
    check("s1.done", 64'(done), 64'd1);
    check("s1.done_busy", 64'(busy), 64'd0);
    tick();
    check("s1.done_held", 64'(done), 64'd1);

    // Ready stall for 7 cycles; restart from DONE; eoc outside RUN ignored.
    req_ready = 1'b0;
    start_seq(32'h1234_5678);
    check("s2.done_clr", 64'(done), 64'd0);
    check("s2.busy",     64'(busy), 64'd1);
    repeat (SETTLE) tick();
    eoc = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("s2.stall_valid", 64'(req_valid), 64'd1);
      check("s2.stall_addr",  64'(req_addr),  64'(BOOT_ADDR));
      check("s2.stall_data",  64'(req_data),  64'h1234_5678);
      tick();
    end
    eoc = 1'b0;
    req_ready = 1'b1;
    rsp_valid = 1'b1;
    rsp_error = 1'b1;
    check("s2.cyc8_valid", 64'(req_valid), 64'd1);
    tick();
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    check("s2.early_rsp_err",  64'(error),     64'd0);
    check("s2.early_rsp_rspr", 64'(rsp_ready), 64'd1);
    tick();
    check("s2.rsp_wait", 64'(rsp_ready), 64'd1);
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    rsp_error = 1'b0;
    check("s2.error", 64'(error), 64'd1);
    check("s2.err_done", 64'(done), 64'd0);
    check("s2.err_busy", 64'(busy), 64'd0);
    check("s2.err_dbg",  64'(debug_req), 64'd0);
    repeat (3) tick();
    check("s2.err_held", 64'(error), 64'd1);
    check("s2.err_dbg2", 64'(debug_req), 64'd0);

    // Restart from ERROR; a start while busy is ignored.
    req_ready = 1'b1;
    start_seq(32'hA5A5_0001);
    check("s3.err_clr", 64'(error), 64'd0);
    tick();
    start = 1'b1;
    entry = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    repeat (SETTLE - 2) tick();
    check("s3.valid", 64'(req_valid), 64'd1);
    check("s3.data",  64'(req_data),  64'hA5A5_0001);
    tick();
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    check("s3.dbg_on", 64'(debug_req), 64'd1);
    tick();
    check("s3.dbg_off", 64'(debug_req), 64'd0);
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
    check("s3.done", 64'(done), 64'd1);

    // Reset in RSP abandons the sequence; next start accepted.
    start_seq(32'h0000_0100);
    repeat (SETTLE) tick();
    tick();
    check("s4.in_rsp", 64'(rsp_ready), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("s4.rst");
    start_seq(32'h0000_0200);
    check("s4.busy", 64'(busy), 64'd1);
    repeat (SETTLE) tick();
    check("s4.data", 64'(req_data), 64'h0000_0200);
    rst = 1'b1;
    start = 1'b1;
    entry = 32'h0000_0300;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("s4.rst_start_busy", 64'(busy), 64'd0);
    tick();
    check("s4.rst_start_idle", 64'(busy), 64'd0);

`ifdef CACHEPOOL_BOOT_WATCHDOG_EN
    // Watchdog expiry after WDOG cycles in RUN.
    run_to_run(32'h0000_0400);
    for (int i = 1; i < int'(WDOG); i++) begin
      tick();
      check("wd.run_err", 64'(error), 64'd0);
    end
    tick();
    check("wd.error",   64'(error),   64'd1);
    check("wd.timeout", 64'(timeout), 64'd1);
    start_seq(32'h0000_0500);
    check("wd.to_clr", 64'(timeout), 64'd0);
    check("wd.er_clr", 64'(error),   64'd0);
    repeat (SETTLE) tick();
    tick();
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    tick();
    repeat (WDOG - 1) tick();
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
    check("wd.eoc_wins_done", 64'(done),    64'd1);
    check("wd.eoc_wins_err",  64'(error),   64'd0);
    check("wd.eoc_wins_to",   64'(timeout), 64'd0);
`else
    // RUN waits indefinitely without the watchdog.
    run_to_run(32'h0000_0400);
    repeat (WDOG + 10) tick();
    check("nowd.still_busy", 64'(busy),  64'd1);
    check("nowd.no_error",   64'(error), 64'd0);
    eoc = 1'b1;
    tick();
    eoc = 1'b0;
    check("nowd.done", 64'(done), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cachepool_boot_ctrl.md
Name: cachepool_boot_ctrl

Overview:
- Hardware boot sequencer for the CachePool cluster. It replaces the bench-driven boot flow.
- Sequence: wait for the settle window, write the entry point into the cluster peripheral boot-control register over a reqrsp-style request/response port, pulse debug_req to wake the cores, then wait for eoc.
- Sits between the SoC control logic and the cluster wrapper's AXI-in path (through a reqrsp_to_axi converter) and its debug_req_i/eoc_o pins.

Parameters:
- AddrWidth, 48, width of the request address.
- DataWidth, 32, width of the request data; boot register write width.
- BootRegAddr, PeriStartAddr + CLUSTER_BOOT_CONTROL_OFFSET, absolute address of the boot-control register.
- SettleCycles, 1000, idle cycles between start and the boot write; 0 is legal.
- WakePulseCycles, 1, debug_req_o high time in cycles; must be at least 1.
- WatchdogCycles, 2**20, eoc timeout; used only when the optional feature is enabled.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle start request.
- entry_point_i  in  DataWidth  boot address; sampled when start is accepted.
- req_addr_o  out  AddrWidth  request address.
- req_data_o  out  DataWidth  request write data.
- req_write_o  out  1  request is a write.
- req_strb_o  out  DataWidth/8  request byte strobes.
- req_valid_o  out  1  request valid.
- req_ready_i  in  1  request ready.
- rsp_valid_i  in  1  response valid.
- rsp_error_i  in  1  response carries an error.
- rsp_ready_o  out  1  response ready.
- debug_req_o  out  1  core wake pulse, to the cluster debug_req_i.
- eoc_i  in  1  end of computation, from the cluster.
- busy_o  out  1  a sequence is in progress.
- done_o  out  1  sequence completed without error.
- error_o  out  1  sequence aborted (response error or watchdog).

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - State goes to IDLE; all counters clear; the latched entry point clears.
  - Every output is 0.
  - A reset during REQ or RSP abandons the transaction; the downstream converter is reset by the same rst_i.
- Outputs by state:
  - req_addr_o = BootRegAddr, req_write_o = 1, req_strb_o = all ones, req_data_o = latched entry point.
  - These four are constant whenever req_valid_o = 1 and 0 otherwise.
  - busy_o = 1 in SETTLE, REQ, RSP, WAKE and RUN.
- State machine (all outputs are Moore, decoded from the registered state):
  - IDLE: on start_i, latch entry_point_i and load the settle counter = SettleCycles. Go to SETTLE, or directly to REQ if SettleCycles = 0.
  - SETTLE: the counter decrements each cycle; when it reaches 0, go to REQ. Exactly SettleCycles cycles are spent in SETTLE.
  - REQ: req_valid_o = 1.
    - Address, data and strobes must not change while valid is high and ready is low.
    - When req_valid_o and req_ready_i are both high, go to RSP.
  - RSP: rsp_ready_o = 1.
    - rsp_valid_i with rsp_error_i = 1 → ERROR.
    - rsp_valid_i with rsp_error_i = 0 → WAKE with the wake counter = WakePulseCycles.
    - A response arriving in the same cycle as request acceptance is not consumed; rsp_ready_o is low in REQ.
  - WAKE: debug_req_o = 1 for exactly WakePulseCycles cycles, then go to RUN.
  - RUN: eoc_i high → DONE.
  - DONE: done_o = 1 and is held. ERROR: error_o = 1 and is held.
- start_i handling:
  - Ignored while busy_o = 1.
  - In DONE or ERROR, start_i clears done_o/error_o on the next cycle and behaves as it does in IDLE (re-latches the entry point).
- eoc_i is sampled only in RUN; eoc_i high in any other state has no effect.
- Simultaneous events:
  - start_i and rst_i together: reset wins.
  - In RUN, eoc_i and the watchdog expiring in the same cycle: eoc wins → DONE.
- Latency from start to the first req_valid_o: SettleCycles + 1 cycles.

Optional Feature:
- Macro: CACHEPOOL_BOOT_WATCHDOG_EN.
- Enabled:
  - A counter of width $clog2(WatchdogCycles+1) clears on entry to RUN and increments each cycle in RUN.
  - When it reaches WatchdogCycles without eoc_i, go to ERROR.
  - A status output timeout_o (1 bit) is set together with error_o and cleared by rst_i or start_i.
- Disabled: RUN waits for eoc_i indefinitely; there is no timeout_o port and no watchdog counter is synthesized.

Decomposition:
- cachepool_pkg holds:
  - the boot state enum type (IDLE, SETTLE, REQ, RSP, WAKE, RUN, DONE, ERROR);
  - the default BootRegAddr constant;
  - the default settle and watchdog constants.
- Sub-module: one down-counter sub-module, cachepool_boot_cnt (load, enable, zero flag), instantiated for the settle, wake and (optional) watchdog counts.

Test Plan:
- SettleCycles = 4, start_i with entry 0x8000_3000, ready = 1 → req_valid_o is high 5 cycles after start, data = 0x8000_3000, strb = 0xF, write = 1.
- req_ready_i held low for 7 cycles → req_valid_o, address and data stay stable all 7 cycles; the transfer happens on cycle 8.
- Good response, then eoc_i 20 cycles later → debug_req_o is high for exactly WakePulseCycles = 1 cycle; done_o = 1 and busy_o = 0 from the cycle after eoc_i.
- Response with rsp_error_i = 1 → error_o = 1, debug_req_o never asserts; a new start_i clears error_o and a second sequence completes.
- rst_i asserted in the RSP state → next cycle all outputs are 0 and the state is IDLE; start_i in the following cycle is accepted.
- With CACHEPOOL_BOOT_WATCHDOG_EN and WatchdogCycles = 50, no eoc_i → error_o and timeout_o are set 50 cycles after entering RUN; eoc_i on the same cycle → done_o instead.
